// File: rtl/fpu_mul_issue_queue.sv
// rtl/fpu_mul_issue_queue.sv - credit-gated issue queue in front of the fixed-latency FP multiplier
// Tags wait in one FIFO while operands fly; results land in a second FIFO and pair with the tag head.
module fpu_mul_issue_queue #(
    parameter int FRAC_WIDTH = 24,
    parameter int EXP_WIDTH  = 8,
    parameter int TAG_WIDTH  = 5,
    parameter int DEPTH      = 16,
    localparam int DW        = FRAC_WIDTH + EXP_WIDTH
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    input  logic                 reqValidIn,
    output logic                 reqReadyOut,
    input  logic [DW-1:0]        reqAIn,
    input  logic [DW-1:0]        reqBIn,
    input  logic [TAG_WIDTH-1:0] reqTagIn,
    output logic                 mulValidOut,
    output logic [DW-1:0]        mulAOut,
    output logic [DW-1:0]        mulBOut,
    input  logic                 mulValidIn,
    input  logic [DW-1:0]        mulDataIn,
    output logic                 rspValidOut,
    input  logic                 rspReadyIn,
    output logic [DW-1:0]        rspDataOut,
    output logic [TAG_WIDTH-1:0] rspTagOut,
    output logic                 busyOut,
    output logic                 errorOut
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]        r_outstanding;
    logic                 r_mul_valid;
    logic [DW-1:0]        r_mul_a;
    logic [DW-1:0]        r_mul_b;
    logic                 r_error;

    logic [TAG_WIDTH-1:0] r_tag_mem [DEPTH];
    logic [DW-1:0]        r_res_mem [DEPTH];
    logic [PW-1:0]        r_tag_wr_ptr;
    logic [PW-1:0]        r_tag_rd_ptr;
    logic [PW-1:0]        r_res_wr_ptr;
    logic [PW-1:0]        r_res_rd_ptr;

    logic                 w_req_fire;
    logic                 w_rsp_fire;
    logic                 w_tag_empty;
    logic                 w_res_empty;
    logic                 w_res_full;
    logic                 w_res_push;
    logic                 w_res_err;

    // Ready depends only on the credit count, so a full queue reopens one cycle after a pop.
    assign reqReadyOut = (r_outstanding < CW'(DEPTH));
    assign w_req_fire  = reqValidIn & reqReadyOut;
    assign w_rsp_fire  = rspValidOut & rspReadyIn;

    assign w_tag_empty = (r_tag_wr_ptr == r_tag_rd_ptr);
    assign w_res_empty = (r_res_wr_ptr == r_res_rd_ptr);
    assign w_res_full  = (r_res_wr_ptr[AW-1:0] == r_res_rd_ptr[AW-1:0]) &&
                         (r_res_wr_ptr[AW] != r_res_rd_ptr[AW]);

    // A result with no tag waiting or no room is dropped and flagged; credits make this unreachable.
    assign w_res_err   = mulValidIn & (w_res_full | w_tag_empty);
    assign w_res_push  = mulValidIn & ~w_res_full & ~w_tag_empty;

    assign mulValidOut = r_mul_valid;
    assign mulAOut     = r_mul_a;
    assign mulBOut     = r_mul_b;

    assign rspValidOut = ~w_res_empty;
    assign rspDataOut  = r_res_mem[r_res_rd_ptr[AW-1:0]];
    assign rspTagOut   = r_tag_mem[r_tag_rd_ptr[AW-1:0]];

    assign busyOut     = (r_outstanding != '0);
    assign errorOut    = r_error;

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_outstanding <= '0;
        end else if (w_req_fire && !w_rsp_fire) begin
            r_outstanding <= r_outstanding + CW'(1);
        end else if (!w_req_fire && w_rsp_fire) begin
            r_outstanding <= r_outstanding - CW'(1);
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_mul_valid <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            r_mul_valid <= w_req_fire;
            if (w_req_fire) begin
                r_mul_a <= reqAIn;
                r_mul_b <= reqBIn;
            end
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_tag_wr_ptr <= '0;
            r_tag_rd_ptr <= '0;
            r_res_wr_ptr <= '0;
            r_res_rd_ptr <= '0;
        end else begin
            if (w_req_fire) begin
                r_tag_wr_ptr <= r_tag_wr_ptr + PW'(1);
            end
            if (w_res_push) begin
                r_res_wr_ptr <= r_res_wr_ptr + PW'(1);
            end
            if (w_rsp_fire) begin
                r_tag_rd_ptr <= r_tag_rd_ptr + PW'(1);
                r_res_rd_ptr <= r_res_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (w_req_fire) begin
            r_tag_mem[r_tag_wr_ptr[AW-1:0]] <= reqTagIn;
        end
        if (w_res_push) begin
            r_res_mem[r_res_wr_ptr[AW-1:0]] <= mulDataIn;
        end
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            r_error <= 1'b0;
        end else if (w_res_err) begin
            r_error <= 1'b1;
        end
    end

endmodule
